// File: rtl/mcu_sched_pkg.sv
// Shared types and constants for the MCU RAM-cycle scheduler.
package mcu_sched_pkg;

    typedef enum logic [2:0] {
        SLOT_IDLE,
        SLOT_CPU,
        SLOT_DMA,
        SLOT_VID,
        SLOT_SND,
        SLOT_REF
    } slot_t;

    localparam logic [1:0] PH_CPU0 = 2'd0;
    localparam logic [1:0] PH_CPU1 = 2'd1;
    localparam logic [1:0] PH_SH0  = 2'd2;
    localparam logic [1:0] PH_SH1  = 2'd3;

    localparam int unsigned REF_PERIOD_DEF = 32;
    localparam int unsigned REF_URGENT_DEF = 4;

    localparam int unsigned DEFER_W   = 3;
    localparam int unsigned DEFER_MAX = 7;

endpackage

// File: rtl/mcu_ref_timer.sv
// Refresh timer: RAM-cycle counter, pending flag, defer count and overflow pulse.
module mcu_ref_timer
    import mcu_sched_pkg::*;
#(
    parameter int unsigned REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic               clk32,
    input  logic               res,
    input  logic               cyc_end,
    input  logic               slot_eval,
    input  logic               ref_grant,
    input  logic               ref_done,
    output logic               pending,
    output logic [DEFER_W-1:0] defer,
    output logic               ref_ovf
);

    localparam int unsigned CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk32) begin
        if (res) begin
            cnt     <= '0;
            pending <= 1'b0;
            defer   <= '0;
            ref_ovf <= 1'b0;
        end else begin
            ref_ovf <= 1'b0;
            // Defer tracks how many shared slots a pending refresh has lost.
            if (slot_eval) begin
                if (ref_grant) begin
                    defer <= '0;
                end else if (pending && (defer != DEFER_W'(DEFER_MAX))) begin
                    defer <= defer + DEFER_W'(1);
                end
            end
            if (cyc_end) begin
                if (cnt == CNT_W'(REF_PERIOD - 1)) begin
                    cnt     <= '0;
                    pending <= 1'b1;
                    ref_ovf <= pending && !ref_done;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    if (ref_done) begin
                        pending <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mcu_slot_sched.sv
// MCU shared-RAM slot scheduler: CPU half / shared half arbitration and strobes.
// Optional MCU_SNDPRIO_EN lets a twice-denied sound request outrank video.
module mcu_slot_sched
    import mcu_sched_pkg::*;
#(
    parameter int unsigned REF_PERIOD = REF_PERIOD_DEF,
    parameter int unsigned REF_URGENT = REF_URGENT_DEF
) (
    input  logic       clk32,
    input  logic       res,
    input  logic       en8,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       vid_req,
    input  logic       snd_req,
    input  logic       snd_on,
    output logic [1:0] phase,
    output logic       addrsel,
    output logic       ixdmab,
    output logic       refb,
    output logic       snden,
    output logic       vidb,
    output logic       cmpcycb,
    output logic       dcyc_n,
    output logic       sload_n,
    output logic       vidclk,
    output logic       sndclk,
    output logic       ref_ovf
);

    slot_t              cpu_slot;
    slot_t              sh_slot;
    slot_t              sh_pick;
    slot_t              cpu_pick;
    logic               snd_want;
    logic               ref_urgent;
    logic               ref_pending;
    logic [DEFER_W-1:0] ref_defer;
    logic               cyc_end;
    logic               slot_eval;

`ifdef MCU_SNDPRIO_EN
    logic [1:0] snd_deny;
`endif

    assign cyc_end   = en8 && (phase == PH_SH1);
    assign slot_eval = en8 && (phase == PH_CPU1);

    // Next grants for both halves, evaluated from the current request levels.
    always_comb begin
        snd_want   = snd_on && snd_req;
        ref_urgent = ref_pending && (int'(ref_defer) >= int'(REF_URGENT));
        sh_pick    = SLOT_IDLE;
        cpu_pick   = SLOT_IDLE;
`ifdef MCU_SNDPRIO_EN
        if (snd_want && (snd_deny >= 2'd2)) begin
            sh_pick = SLOT_SND;
        end else
`endif
        if (vid_req) begin
            sh_pick = SLOT_VID;
        end else if (ref_urgent) begin
            sh_pick = SLOT_REF;
        end else if (snd_want) begin
            sh_pick = SLOT_SND;
        end else if (ref_pending) begin
            sh_pick = SLOT_REF;
        end
        if (dma_req) begin
            cpu_pick = SLOT_DMA;
        end else if (cpu_req) begin
            cpu_pick = SLOT_CPU;
        end
    end

    always_ff @(posedge clk32) begin
        if (res) begin
            phase    <= PH_CPU0;
            cpu_slot <= SLOT_IDLE;
            sh_slot  <= SLOT_IDLE;
            addrsel  <= 1'b0;
            ixdmab   <= 1'b1;
            refb     <= 1'b1;
            snden    <= 1'b0;
            vidb     <= 1'b1;
            cmpcycb  <= 1'b1;
            dcyc_n   <= 1'b1;
            sload_n  <= 1'b1;
            vidclk   <= 1'b0;
            sndclk   <= 1'b0;
`ifdef MCU_SNDPRIO_EN
            snd_deny <= 2'd0;
`endif
        end else begin
            sload_n <= 1'b1;
            vidclk  <= 1'b0;
            sndclk  <= 1'b0;
            if (en8) begin
                phase <= phase + 2'd1;
                case (phase)
                    PH_CPU0: begin
                        cmpcycb <= (cpu_slot != SLOT_CPU);
                    end
                    PH_CPU1: begin
                        addrsel <= 1'b1;
                        cmpcycb <= 1'b1;
                        ixdmab  <= 1'b1;
                        sh_slot <= sh_pick;
                        vidb    <= (sh_pick != SLOT_VID);
                        dcyc_n  <= (sh_pick != SLOT_VID);
                        snden   <= (sh_pick == SLOT_SND);
                        refb    <= (sh_pick != SLOT_REF);
`ifdef MCU_SNDPRIO_EN
                        if (!snd_want || (sh_pick == SLOT_SND)) begin
                            snd_deny <= 2'd0;
                        end else if (snd_deny != 2'd2) begin
                            snd_deny <= snd_deny + 2'd1;
                        end
`endif
                    end
                    PH_SH1: begin
                        // Close the shared slot and open the next CPU half.
                        addrsel  <= 1'b0;
                        vidb     <= 1'b1;
                        dcyc_n   <= 1'b1;
                        snden    <= 1'b0;
                        refb     <= 1'b1;
                        vidclk   <= (sh_slot == SLOT_VID);
                        sload_n  <= (sh_slot != SLOT_VID);
                        sndclk   <= (sh_slot == SLOT_SND);
                        sh_slot  <= SLOT_IDLE;
                        cpu_slot <= cpu_pick;
                        ixdmab   <= (cpu_pick != SLOT_DMA);
                    end
                    default: ;
                endcase
            end
        end
    end

    mcu_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .clk32     (clk32),
        .res       (res),
        .cyc_end   (cyc_end),
        .slot_eval (slot_eval),
        .ref_grant (sh_pick == SLOT_REF),
        .ref_done  (sh_slot == SLOT_REF),
        .pending   (ref_pending),
        .defer     (ref_defer),
        .ref_ovf   (ref_ovf)
    );

endmodule

// File: tb/tb_mcu_slot_sched.sv
// Scoreboard bench for mcu_slot_sched: per-RAM-cycle reference model feeds a queue.
module tb_mcu_slot_sched;
    import mcu_sched_pkg::*;

    localparam int T_PERIOD = 32;
    localparam int T_URGENT = 4;

    logic       clk32 = 1'b0;
    logic       res = 1'b1;
    logic       en8 = 1'b0;
    logic       cpu_req = 1'b0;
    logic       dma_req = 1'b0;
    logic       vid_req = 1'b0;
    logic       snd_req = 1'b0;
    logic       snd_on = 1'b0;
    logic [1:0] phase;
    logic       addrsel, ixdmab, refb, snden, vidb, cmpcycb;
    logic       dcyc_n, sload_n, vidclk, sndclk, ref_ovf;

    mcu_slot_sched dut (
        .clk32   (clk32),
        .res     (res),
        .en8     (en8),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .vid_req (vid_req),
        .snd_req (snd_req),
        .snd_on  (snd_on),
        .phase   (phase),
        .addrsel (addrsel),
        .ixdmab  (ixdmab),
        .refb    (refb),
        .snden   (snden),
        .vidb    (vidb),
        .cmpcycb (cmpcycb),
        .dcyc_n  (dcyc_n),
        .sload_n (sload_n),
        .vidclk  (vidclk),
        .sndclk  (sndclk),
        .ref_ovf (ref_ovf)
    );

    always #5 clk32 = ~clk32;

    typedef struct {
        slot_t cpu;
        slot_t sh;
        bit    ovf;
    } exp_t;

    exp_t  sbq[$];
    exp_t  last;
    bit    have_last;
    int    total = 0;
    int    bad = 0;
    int    vid_cnt = 0;
    int    cyc_idx, first_ref, first_ovf;
    slot_t m_cpu;
    int    m_cnt, m_defer, m_deny, m_vidn;
    bit    m_pend;

    always @(posedge clk32) if (vidclk) vid_cnt <= vid_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic e);
        en8 = e;
        @(posedge clk32);
        #1;
    endtask

    task automatic tick();
        step(1'b0); step(1'b0); step(1'b0); step(1'b1);
    endtask

    task automatic model_reset();
        m_cpu = SLOT_IDLE; m_cnt = 0; m_defer = 0; m_deny = 0; m_pend = 0; m_vidn = 0;
        have_last = 0; cyc_idx = 0; first_ref = 0; first_ovf = 0;
        sbq.delete();
    endtask

    task automatic do_reset();
        cpu_req = 0; dma_req = 0; vid_req = 0; snd_req = 0; snd_on = 0;
        res = 1'b1;
        step(1'b0); step(1'b0);
        res = 1'b0;
        model_reset();
    endtask

    // One RAM cycle of the reference model; lowest priority is assigned first and overridden.
    task automatic model_cycle(input bit c, input bit d, input bit v, input bit sr, input bit so);
        exp_t  e;
        slot_t sh;
        bit    sw, ovf;
        sw = so && sr;
        sh = SLOT_IDLE;
        if (m_pend) sh = SLOT_REF;
        if (sw) sh = SLOT_SND;
        if (m_pend && m_defer >= T_URGENT) sh = SLOT_REF;
        if (v) sh = SLOT_VID;
`ifdef MCU_SNDPRIO_EN
        if (sw && m_deny >= 2) sh = SLOT_SND;
        m_deny = (!sw || sh == SLOT_SND) ? 0 : m_deny + 1;
`endif
        if (sh == SLOT_REF) m_defer = 0;
        else if (m_pend && m_defer < 7) m_defer++;
        ovf = 0;
        if (m_cnt == T_PERIOD - 1) begin
            m_cnt = 0;
            ovf = m_pend && (sh != SLOT_REF);
            m_pend = 1;
        end else begin
            m_cnt++;
            if (sh == SLOT_REF) m_pend = 0;
        end
        if (sh == SLOT_VID) m_vidn++;
        e.cpu = m_cpu; e.sh = sh; e.ovf = ovf;
        sbq.push_back(e);
        m_cpu = d ? SLOT_DMA : (c ? SLOT_CPU : SLOT_IDLE);
    endtask

    // Entered at phase 0 just after the en8 edge; leaves at the next cycle's phase 0.
    task automatic run_cycle(input bit c, input bit d, input bit v, input bit sr, input bit so);
        exp_t e;
        if (have_last) begin
            check("vidclk", vidclk, last.sh == SLOT_VID);
            check("sload_n", sload_n, last.sh != SLOT_VID);
            check("sndclk", sndclk, last.sh == SLOT_SND);
            check("ref_ovf", ref_ovf, last.ovf);
            if (ref_ovf && first_ovf == 0) first_ovf = cyc_idx;
        end
        cpu_req = c; dma_req = d; vid_req = v; snd_req = sr; snd_on = so;
        model_cycle(c, d, v, sr, so);
        if (sbq.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        cyc_idx++;
        check("ph0", phase, 0);
        check("ph0_addrsel", addrsel, 0);
        check("ph0_ixdmab", ixdmab, e.cpu != SLOT_DMA);
        check("ph0_cmpcycb", cmpcycb, 1);
        tick();
        check("ph1", phase, 1);
        check("ph1_addrsel", addrsel, 0);
        check("ph1_ixdmab", ixdmab, e.cpu != SLOT_DMA);
        check("ph1_cmpcycb", cmpcycb, e.cpu != SLOT_CPU);
        tick();
        check("ph2_addrsel", addrsel, 1);
        check("ph2_ixdmab", ixdmab, 1);
        check("ph2_cmpcycb", cmpcycb, 1);
        check("ph2_vidb", vidb, e.sh != SLOT_VID);
        check("ph2_dcyc_n", dcyc_n, e.sh != SLOT_VID);
        check("ph2_snden", snden, e.sh == SLOT_SND);
        check("ph2_refb", refb, e.sh != SLOT_REF);
        if (!refb && first_ref == 0) first_ref = cyc_idx;
        tick();
        check("ph3", phase, 3);
        check("ph3_vidb", vidb, e.sh != SLOT_VID);
        check("ph3_snden", snden, e.sh == SLOT_SND);
        tick();
        last = e;
        have_last = 1;
    endtask

    initial begin
        int vbase, mbase;
        do_reset();
        check("rst_phase", phase, 0);
        check("rst_addrsel", addrsel, 0);
        check("rst_ixdmab", ixdmab, 1);
        check("rst_refb", refb, 1);
        check("rst_snden", snden, 0);
        check("rst_vidb", vidb, 1);
        check("rst_cmpcycb", cmpcycb, 1);
        check("rst_dcyc_n", dcyc_n, 1);
        check("rst_sload_n", sload_n, 1);
        check("rst_vidclk", vidclk, 0);
        check("rst_sndclk", sndclk, 0);
        check("rst_ref_ovf", ref_ovf, 0);

        // CPU held, then DMA contention and release.
        for (int i = 0; i < 5; i++) run_cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0);

        // Continuous video with sound pending: refresh starves until overflow.
        do_reset();
        run_cycle(0, 0, 1, 1, 1);
        vbase = vid_cnt;
        mbase = m_vidn - 1;
        for (int i = 0; i < 16; i++) run_cycle(0, 0, 1, 1, 1);
        check("vidclk_count", vid_cnt - vbase, m_vidn - mbase - ((last.sh == SLOT_VID) ? 1 : 0));
        for (int i = 0; i < 50; i++) run_cycle(0, 0, 1, 1, 1);
        check("ovf_cycle", first_ovf, 64);
        check("no_ref_in_video", first_ref, 0);

        // Sound only: refresh waits until defer reaches the urgent threshold.
        do_reset();
        for (int i = 0; i < 40; i++) run_cycle(0, 0, 0, 1, 1);
        check("first_ref_cycle", first_ref, T_PERIOD + T_URGENT + 1);

        // Reset in the middle of a video slot.
        do_reset();
        run_cycle(0, 0, 1, 0, 0);
        run_cycle(0, 0, 1, 0, 0);
        tick();
        tick();
        check("mid_vidb", vidb, 0);
        step(1'b0);
        res = 1'b1;
        step(1'b0);
        check("mid_rst_phase", phase, 0);
        check("mid_rst_vidb", vidb, 1);
        check("mid_rst_dcyc_n", dcyc_n, 1);
        check("mid_rst_vidclk", vidclk, 0);
        check("mid_rst_sload_n", sload_n, 1);
        res = 1'b0;
        vid_req = 1'b0;
        model_reset();
        step(1'b0);
        check("post_rst_vidclk", vidclk, 0);
        check("post_rst_sload_n", sload_n, 1);
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcu_slot_sched.md
Name: mcu_slot_sched

Overview:
- Memory-cycle scheduler for the MCU shared RAM address bus.
- Divides each 500 ns RAM cycle (four 8 MHz ticks) into a CPU half and a shared half, and grants each half to one requester.
- Drives the select lines that steer the address mux: addrsel, ixdmab, refb, snden, vidb.
- Generates the per-slot strobes consumed by the video counter, sound counter, shifter and DTACK logic.

Parameters:
- REF_PERIOD, 32: RAM cycles between refresh requests (32 cycles = 16 us).
- REF_URGENT, 4: denied shared slots after which a pending refresh outranks sound.

Ports:
- clk32 in 1: 32 MHz system clock.
- res in 1: synchronous, active-high reset.
- en8 in 1: 8 MHz enable; one clk32-wide pulse every 4 clk32.
- cpu_req in 1: CPU RAM access pending (level).
- dma_req in 1: disk DMA owns the CPU half (level).
- vid_req in 1: video fetch wanted, i.e. display-enable window (level).
- snd_req in 1: sound FIFO request, SREQ (level).
- snd_on in 1: sound DMA enabled.
- phase out 2: tick index 0..3 within the RAM cycle.
- addrsel out 1: 0 in the CPU half, 1 in the shared half.
- ixdmab out 1: 0 while the CPU half is granted to DMA.
- refb out 1: 0 during a refresh slot.
- snden out 1: 1 during a sound slot.
- vidb out 1: 0 during a video slot.
- cmpcycb out 1: 0 for the completion tick of a granted CPU slot (feeds DTACK).
- dcyc_n out 1: 0 during a video slot (shifter load cycle).
- sload_n out 1: one-clk32 low pulse at the end of a video slot.
- vidclk out 1: one-clk32 pulse advancing the video address counter.
- sndclk out 1: one-clk32 pulse advancing the sound address counter.
- ref_ovf out 1: one-clk32 pulse when a refresh request is lost.

Behaviour:
- Reset values: phase=0, addrsel=0, ixdmab=1, refb=1, snden=0, vidb=1, cmpcycb=1, dcyc_n=1, sload_n=1, vidclk=0, sndclk=0, ref_ovf=0. Refresh counter, pending flag and defer count are cleared.
- Reset mid-slot: grant is abandoned, no end-of-slot pulses are emitted, and the next slot starts at phase 0.
- Phase: increments on en8 and wraps 3->0. All outputs are registered and change only on en8 edges, except the one-clk32 pulses, which fire on the same clk32 as the en8.
- CPU half (phases 0-1), decided on en8 at phase 3:
  - dma_req wins: ixdmab=0.
  - else cpu_req: CPU grant.
  - else idle.
  - The grant is latched for the whole half; a request dropping mid-half does not abort it.
- cmpcycb: low through phase 1 of a CPU grant only; never for a DMA grant.
- Shared half (phases 2-3), decided on en8 at phase 1. Priority:
  1. vid_req
  2. refresh pending AND defer >= REF_URGENT
  3. snd_on AND snd_req
  4. refresh pending
  5. idle
- Shared-half encodings:
  - Video: vidb=0, dcyc_n=0.
  - Sound: snden=1.
  - Refresh: refb=0.
  - Idle: refb=1, snden=0, vidb=1.
- End-of-slot pulses, on the en8 that ends phase 3:
  - Video slot: vidclk=1 and sload_n=0.
  - Sound slot: sndclk=1.
- Refresh timer:
  - Counts RAM cycles 0..REF_PERIOD-1; on wrap it sets pending.
  - If pending is already set at wrap, ref_ovf pulses and pending stays set.
  - defer increments (saturating at 7) on each shared slot where pending is set but refresh is not granted; it clears when refresh is granted.
  - Granting refresh clears pending at the end of the slot.
  - A wrap coinciding with refresh completion leaves pending set, with no ovf.
- Simultaneous cpu_req and dma_req: DMA wins; the CPU waits one RAM cycle.

Optional Feature:
- Macro MCU_SNDPRIO_EN.
- Defined: a sound request denied in 2 consecutive shared slots outranks video in the next shared slot. The denial count clears on a sound grant or when snd_req drops. Urgent refresh still ranks below video.
- Undefined: video always wins and sound can starve for a whole display line.

Decomposition:
- Package mcu_sched_pkg holds:
  - slot enum: SLOT_IDLE, SLOT_CPU, SLOT_DMA, SLOT_VID, SLOT_SND, SLOT_REF;
  - phase constants PH_CPU0, PH_CPU1, PH_SH0, PH_SH1;
  - defaults for REF_PERIOD and REF_URGENT.
- One sub-module, mcu_ref_timer, owns the refresh counter, pending flag, defer count and ref_ovf.

Test Plan:
- Reset, then cpu_req=1 held → CPU grant every cycle; addrsel toggles 0,0,1,1 per phase; cmpcycb low at phase 1 of every cycle; ixdmab=1.
- cpu_req=1 and dma_req=1 together → ixdmab=0 in the CPU half, cmpcycb stays 1; after dma_req drops, the CPU grant starts in the next cycle.
- vid_req=1 and snd_req=1, snd_on=1, REF_PERIOD=32 → every shared slot is video, with 16 vidclk pulses per 16 RAM cycles. Refresh is deferred; ref_ovf pulses at cycle 64 of continuous video. With MCU_SNDPRIO_EN, every third shared slot is sound.
- vid_req=0, snd_req=1 continuous → sndclk every cycle. After REF_PERIOD cycles, one refresh slot (refb=0) appears only once defer reaches 4; it then takes the next shared slot.
- res asserted at phase 2 of a video slot → next clk32: vidb=1, dcyc_n=1, phase=0; no vidclk or sload_n pulse.
